// File: rtl/pkt_framer_tx.sv
// -----------------------------------------------------------------------------
// pkt_framer_tx
//   Transmit-side packet framer. Accepts packet requests (length in beats)
//   over a valid/ready handshake. Each accepted request becomes a val/sop/eop
//   beat stream whose payload is the beat index. Framing is always one sop,
//   then one eop, with no sop in between. After every accepted eop the framer
//   inserts MIN_GAP idle cycles. New packets start only while the port is
//   enabled.
//
// Parameters
//   LEN_W    width of req_len (legal length 1..2^LEN_W-1; 0 is treated as 1)
//   DATA_W   width of tx_data
//   MIN_GAP  idle cycles forced after each accepted eop beat (0..15)
//
// Ports
//   clk              clock
//   reset_L          synchronous, active-low reset
//   cfg_port_enable  1 = new requests may be accepted (sampled in IDLE only)
//   req_val/req_rdy  request handshake; req_len is sampled at acceptance
//   tx_rdy           downstream accepts the current beat
//   val/sop/eop      beat framing (registered)
//   tx_data          beat payload = beat index
//   busy             state != IDLE (0 in RESET)
//   pkt_cnt          completed packets, wraps 0xFFFF -> 0
//
// Optional feature (macro FRAMER_ERR_INJECT_EN)
//   Adds inj_drop_eop / inj_dup_sop, sampled at request acceptance:
//   drop_eop sends the last beat with eop=0 (packet is still counted);
//   dup_sop also raises sop on beat 1 when the packet has two or more beats.
// -----------------------------------------------------------------------------
module pkt_framer_tx #(
  parameter int LEN_W   = 8,
  parameter int DATA_W  = 8,
  parameter int MIN_GAP = 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              cfg_port_enable,
  input  logic              req_val,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_rdy,
`ifdef FRAMER_ERR_INJECT_EN
  input  logic              inj_drop_eop,
  input  logic              inj_dup_sop,
`endif
  input  logic              tx_rdy,
  output logic              val,
  output logic              sop,
  output logic              eop,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic [15:0]       pkt_cnt
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [3:0]       GAP_LOAD = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [3:0]       gap_cnt;
  logic             drop_q;
  logic             dup_q;
  logic             inj_drop_sel;
  logic             inj_dup_sel;
  logic             accept;
  logic             last_beat;
  logic [LEN_W-1:0] next_cnt;
  logic [LEN_W-1:0] acc_len;

  // A zero-length request still produces a single beat.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l == '0) ? LEN_ONE : l;
  endfunction

  // Payload is the beat index, truncated or zero-extended to DATA_W.
  function automatic logic [DATA_W-1:0] beat_data(input logic [LEN_W-1:0] b);
    return DATA_W'(b);
  endfunction

`ifdef FRAMER_ERR_INJECT_EN
  assign inj_drop_sel = inj_drop_eop;
  assign inj_dup_sel  = inj_dup_sop;
`else
  assign inj_drop_sel = 1'b0;
  assign inj_dup_sel  = 1'b0;
`endif

  // Enable is looked at only in IDLE, so dropping it mid-packet never
  // truncates the packet in flight.
  assign req_rdy   = (state == ST_IDLE) & cfg_port_enable;
  assign accept    = req_val & req_rdy;
  assign acc_len   = clamp_len(req_len);
  assign next_cnt  = beat_cnt + LEN_ONE;
  // Tracks the true final beat independently of the eop output, so an
  // injected eop drop still ends the packet.
  assign last_beat = (beat_cnt == len_q - LEN_ONE);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state    <= ST_RESET;
      val      <= 1'b0;
      sop      <= 1'b0;
      eop      <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      pkt_cnt  <= 16'd0;
      len_q    <= LEN_ONE;
      beat_cnt <= '0;
      gap_cnt  <= 4'd0;
      drop_q   <= 1'b0;
      dup_q    <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (accept) begin
            len_q    <= acc_len;
            beat_cnt <= '0;
            drop_q   <= inj_drop_sel;
            dup_q    <= inj_dup_sel;
            val      <= 1'b1;
            sop      <= 1'b1;
            eop      <= (acc_len == LEN_ONE) & ~inj_drop_sel;
            tx_data  <= '0;
            busy     <= 1'b1;
            state    <= ST_SEND;
          end
        end

        // Outputs only advance on an accepted beat; while tx_rdy is low
        // every registered output simply holds.
        ST_SEND: begin
          if (tx_rdy) begin
            if (last_beat) begin
              pkt_cnt <= pkt_cnt + 16'd1;
              val     <= 1'b0;
              sop     <= 1'b0;
              eop     <= 1'b0;
              if (MIN_GAP == 0) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end else begin
              beat_cnt <= next_cnt;
              sop      <= dup_q & (beat_cnt == '0);
              eop      <= (next_cnt == len_q - LEN_ONE) & ~drop_q;
              tx_data  <= beat_data(next_cnt);
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        default: begin
          state <= ST_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_framer_tx.sv
module tb_pkt_framer_tx;

  localparam int LEN_W   = 8;
  localparam int DATA_W  = 8;
  localparam int MIN_GAP = 1;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset_L;
  logic              cfg_port_enable;
  logic              req_val;
  logic [LEN_W-1:0]  req_len;
  logic              req_rdy;
  logic              tx_rdy;
  logic              val;
  logic              sop;
  logic              eop;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic [15:0]       pkt_cnt;
`ifdef FRAMER_ERR_INJECT_EN
  logic              inj_drop_eop;
  logic              inj_dup_sop;
`endif

  int    errors = 0;
  int    checks = 0;
  int    exp_pkt = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  pkt_framer_tx #(.LEN_W(LEN_W), .DATA_W(DATA_W), .MIN_GAP(MIN_GAP)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .cfg_port_enable (cfg_port_enable),
    .req_val         (req_val),
    .req_len         (req_len),
    .req_rdy         (req_rdy),
`ifdef FRAMER_ERR_INJECT_EN
    .inj_drop_eop    (inj_drop_eop),
    .inj_dup_sop     (inj_dup_sop),
`endif
    .tx_rdy          (tx_rdy),
    .val             (val),
    .sop             (sop),
    .eop             (eop),
    .tx_data         (tx_data),
    .busy            (busy),
    .pkt_cnt         (pkt_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on each accepted beat, hold stability while
  // stalled, and minimum spacing between an accepted eop and the next sop.
  logic [3+DATA_W-1:0] prev_out;
  bit                  prev_stall = 1'b0;
  bit                  have_eop   = 1'b0;
  int                  since_eop  = 0;

  always @(negedge clk) begin
    if (!reset_L) begin
      have_eop   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      since_eop++;
      if (prev_stall)
        check("hold_stable", {val, sop, eop, tx_data}, prev_out);
      if (val && tx_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {sop, eop, tx_data}, 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_sop_eop_data", {sop, eop, tx_data}, {e.sop, e.eop, e.data});
        end
        if (sop && have_eop)
          check("min_gap_before_sop", 32'(since_eop >= MIN_GAP + 2), 32'd1);
        if (eop) begin
          have_eop  = 1'b1;
          since_eop = 0;
        end
      end
      prev_stall = val && !tx_rdy;
      prev_out   = {val, sop, eop, tx_data};
    end
  end

  // Issue one request, push its expected beats once it is seen accepted.
  task automatic send_req(input int len, input bit drop, input bit dup);
    int    l;
    int    n;
    beat_t b;
    logic [31:0] lv;
    l  = (len == 0) ? 1 : len;
    lv = 32'(len);
    req_val = 1'b1;
    req_len = lv[LEN_W-1:0];
`ifdef FRAMER_ERR_INJECT_EN
    inj_drop_eop = drop;
    inj_dup_sop  = dup;
`endif
    n = 0;
    @(negedge clk);
    while (!req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy) begin
      check("req_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_val = 1'b0;
      return;
    end
    for (int i = 0; i < l; i++) begin
      lv     = 32'(i);
      b.sop  = (i == 0) || (dup && i == 1);
      b.eop  = (i == l - 1) && !drop;
      b.data = lv[DATA_W-1:0];
      exp_q.push_back(b);
    end
    exp_pkt++;
    @(posedge clk); #1;
    req_val = 1'b0;
    req_len = 8'hAA;  // later changes must be ignored
`ifdef FRAMER_ERR_INJECT_EN
    inj_drop_eop = 1'b0;
    inj_dup_sop  = 1'b0;
`endif
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(posedge clk); #1;
    while ((exp_q.size() != 0 || busy || val) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("wait_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_L = 1'b0;
    cfg_port_enable = 1'b0;
    req_val = 1'b0;
    req_len = '0;
    tx_rdy  = 1'b1;
`ifdef FRAMER_ERR_INJECT_EN
    inj_drop_eop = 1'b0;
    inj_dup_sop  = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {req_rdy, val, sop, eop, tx_data, busy, pkt_cnt}, 32'd0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    cfg_port_enable = 1'b1;
    @(negedge clk);
    check("reset_state_busy_rdy", {busy, req_rdy}, 2'b00);
    @(negedge clk);
    check("idle_req_rdy", {busy, req_rdy}, 2'b01);

    // 4-beat packet, full-rate; latency, then one GAP cycle
    @(posedge clk); #1;
    send_req(4, 1'b0, 1'b0);
    @(negedge clk);
    check("first_beat_latency", {val, sop, tx_data}, {1'b1, 1'b1, 8'd0});
    n = 0;
    while (!(val && eop) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("eop_seen", {val, eop}, 2'b11);
    @(negedge clk);
    check("gap_cycle", {val, req_rdy, busy, pkt_cnt}, {1'b0, 1'b0, 1'b1, 16'd1});
    @(negedge clk);
    check("idle_after_gap", {val, req_rdy, busy}, 3'b010);

    // 3-beat packet with beat 1 stalled for two cycles
    @(posedge clk); #1;
    send_req(3, 1'b0, 1'b0);
    @(posedge clk); #1;
    tx_rdy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stalled_beat1", {val, sop, eop, tx_data}, {1'b1, 1'b0, 1'b0, 8'd1});
    end
    @(posedge clk); #1;
    tx_rdy = 1'b1;
    @(negedge clk);
    check("stalled_beat1_third", {val, sop, eop, tx_data}, {1'b1, 1'b0, 1'b0, 8'd1});
    wait_done();
    check("pkt_cnt_after_3", pkt_cnt, 32'(exp_pkt));

    // Zero and one-beat packets
    send_req(0, 1'b0, 1'b0);
    @(negedge clk);
    check("len0_single_beat", {val, sop, eop, tx_data}, {1'b1, 1'b1, 1'b1, 8'd0});
    wait_done();
    send_req(1, 1'b0, 1'b0);
    wait_done();
    check("pkt_cnt_after_len01", pkt_cnt, 32'(exp_pkt));

    // Back-to-back requests exercise the minimum gap
    send_req(2, 1'b0, 1'b0);
    send_req(1, 1'b0, 1'b0);
    send_req(3, 1'b0, 1'b0);
    wait_done();
    check("pkt_cnt_b2b", pkt_cnt, 32'(exp_pkt));

    // Port disabled: nothing accepted
    cfg_port_enable = 1'b0;
    req_val = 1'b1;
    req_len = 8'd2;
    repeat (3) begin
      @(negedge clk);
      check("disabled_no_accept", {req_rdy, val, busy}, 3'b000);
    end
    @(posedge clk); #1;
    req_val = 1'b0;
    cfg_port_enable = 1'b1;

    // Enable drops during a 5-beat packet: packet completes, next is held off
    send_req(5, 1'b0, 1'b0);
    cfg_port_enable = 1'b0;
    req_val = 1'b1;
    req_len = 8'd2;
    wait_done();
    repeat (3) begin
      @(negedge clk);
      check("disabled_after_pkt", {req_rdy, val, busy}, 3'b000);
    end
    check("pkt_cnt_after_5", pkt_cnt, 32'(exp_pkt));
    @(posedge clk); #1;
    req_val = 1'b0;
    cfg_port_enable = 1'b1;

`ifdef FRAMER_ERR_INJECT_EN
    send_req(2, 1'b1, 1'b0);
    wait_done();
    check("pkt_cnt_drop_eop", pkt_cnt, 32'(exp_pkt));
    send_req(3, 1'b0, 1'b1);
    wait_done();
    check("pkt_cnt_dup_sop", pkt_cnt, 32'(exp_pkt));
`endif

    // Reset in the middle of a 6-beat packet abandons it
    send_req(6, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_L = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_pkt = 0;
    @(negedge clk);
    check("midpkt_reset_outputs", {req_rdy, val, sop, eop, tx_data, busy, pkt_cnt}, 32'd0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    @(posedge clk); #1;
    send_req(2, 1'b0, 1'b0);
    wait_done();
    check("pkt_cnt_after_reset", pkt_cnt, 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
